// File: rtl/mul_issue_pkg.sv
// Shared types and default sizing for the multiplier issue/retire controller.
package mul_issue_pkg;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 80;
  localparam int DEF_CNT_W   = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_e;
endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Operand and result valid/ready handshakes between a client (master) and the controller (slave).
interface mul_issue_ctrl_if #(parameter int WIDTH = mul_issue_pkg::DEF_WIDTH) ();
  logic               op_valid;
  logic               op_ready;
  logic [WIDTH-1:0]   op_q;
  logic [WIDTH-1:0]   op_m;
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] res_data;
  logic               res_err;

  modport master (
    output op_valid, op_q, op_m, res_ready,
    input  op_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  op_valid, op_q, op_m, res_ready,
    output op_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/mul_issue_ctrl_wd_counter.sv
// Watchdog counter: synchronous clear, count enable, terminal flag when count equals limit.
module wd_counter
  import mul_issue_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == limit);
endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/retire controller for the signed Robertson multiplier: holds operands,
// sequences rst/bgn/fin and returns the product or a timeout error.
module mul_issue_ctrl
  import mul_issue_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  mul_issue_ctrl_if.slave    bus,
  output logic               busy,
  output logic               mul_rst,
  output logic               mul_bgn,
  output logic [WIDTH-1:0]   mul_q,
  output logic [WIDTH-1:0]   mul_m,
  input  logic [2*WIDTH-1:0] mul_outbus,
  input  logic               mul_fin
);
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opq_q, opq_d;
  logic [WIDTH-1:0]   opm_q, opm_d;
  logic [2*WIDTH-1:0] res_data_q, res_data_d;
  logic               res_err_q, res_err_d;
  logic               wd_clr, wd_en, wd_tc;
  logic [CNT_W-1:0]   wd_cnt;

  wd_counter #(.CNT_W(CNT_W)) u_wd (
    .clk   (clk),
    .rst   (rst),
    .clr   (wd_clr),
    .en    (wd_en),
    .limit (CNT_W'(TIMEOUT - 1)),
    .cnt   (wd_cnt),
    .tc    (wd_tc)
  );

  always_comb begin
    state_d    = state_q;
    opq_d      = opq_q;
    opm_d      = opm_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.op_valid) begin
          opq_d   = bus.op_q;
          opm_d   = bus.op_m;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD:  state_d = ST_START;
      ST_START: begin
        wd_clr  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        // A late fin coinciding with the timeout still delivers the product.
        if (mul_fin) begin
          res_data_d = mul_outbus;
          res_err_d  = 1'b0;
          state_d    = ST_DONE;
        end else if (wd_tc) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.res_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      opq_q      <= '0;
      opm_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opq_q      <= opq_d;
      opm_q      <= opm_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  // Outputs decode from the state register only, so bgn can never overlap mul_rst.
  assign bus.op_ready  = (state_q == ST_IDLE);
  assign bus.res_valid = (state_q == ST_DONE);
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign busy          = (state_q != ST_IDLE);
  assign mul_rst       = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign mul_bgn       = (state_q == ST_START);
  assign mul_q         = opq_q;
  assign mul_m         = opm_q;

  logic unused_ok;
  assign unused_ok = ^wd_cnt;
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural multiplier raising fin 52 cycles after bgn.
module tb_mul_issue_ctrl;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 80;
  localparam int CNT_W   = 7;

  logic               clk = 1'b0;
  logic               rst;
  logic               busy, mul_rst, mul_bgn, mul_fin;
  logic [WIDTH-1:0]   mul_q, mul_m;
  logic [2*WIDTH-1:0] mul_outbus;

  mul_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mul_issue_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .mul_rst    (mul_rst),
    .mul_bgn    (mul_bgn),
    .mul_q      (mul_q),
    .mul_m      (mul_m),
    .mul_outbus (mul_outbus),
    .mul_fin    (mul_fin)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: fin latches 52 cycles after bgn, cleared by mul_rst.
  logic        fin_en    = 1'b1;
  logic        model_fin = 1'b0;
  logic        running   = 1'b0;
  int          mcnt      = 0;
  logic [31:0] qx, mx;
  assign qx         = {{16{mul_q[15]}}, mul_q};
  assign mx         = {{16{mul_m[15]}}, mul_m};
  assign mul_outbus = qx * mx;
  assign mul_fin    = model_fin & fin_en;

  always @(posedge clk) begin
    if (mul_rst) begin
      running   <= 1'b0;
      mcnt      <= 0;
      model_fin <= 1'b0;
    end else if (mul_bgn) begin
      running <= 1'b1;
      mcnt    <= 1;
    end else if (running && !model_fin) begin
      mcnt <= mcnt + 1;
      if (mcnt + 1 == 52) model_fin <= 1'b1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},      busy,          0);
    chk({tag, "_op_ready"},  bus.op_ready,  1);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_data"},  bus.res_data,  0);
    chk({tag, "_res_err"},   bus.res_err,   0);
    chk({tag, "_mul_rst"},   mul_rst,       1);
    chk({tag, "_mul_bgn"},   mul_bgn,       0);
    chk({tag, "_mul_q"},     mul_q,         0);
    chk({tag, "_mul_m"},     mul_m,         0);
  endtask

  typedef struct {
    logic [15:0] q;
    logic [15:0] m;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          hold;
    bit          no_fin;
  } vec_t;

  // Issue one op at the current negedge; k counts cycles after the acceptance edge.
  task automatic run_vec(input vec_t v, input int idx);
    int   k, k_fin, k_res, bgn_cnt, bgn_k, wait_n;
    bit   op_ok, hold_ok;
    logic [31:0] d0;
    logic        e0;
    string tag;
    tag    = $sformatf("v%0d", idx);
    fin_en = !v.no_fin;
    wait_n = 0;
    while (bus.op_ready !== 1'b1 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    chk({tag, "_op_ready_before"}, bus.op_ready, 1);
    bus.op_valid  = 1'b1;
    bus.op_q      = v.q;
    bus.op_m      = v.m;
    bus.res_ready = 1'b0;
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op_q     = 16'($urandom);
    bus.op_m     = 16'($urandom);
    k = 1; k_fin = -1; k_res = -1; bgn_cnt = 0; bgn_k = -1; op_ok = 1'b1;
    while (k <= 150) begin
      if (bus.res_valid === 1'b1) begin
        k_res = k;
        break;
      end
      if (mul_q !== v.q || mul_m !== v.m || bus.op_ready !== 1'b0 ||
          busy !== 1'b1 || mul_rst !== 1'b0) op_ok = 1'b0;
      if (mul_bgn === 1'b1) begin
        bgn_cnt++;
        bgn_k = k;
      end
      if (mul_fin === 1'b1 && k_fin < 0) k_fin = k;
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"},     k_res,   v.exp_lat);
    chk({tag, "_hold_ops"},    op_ok,   1);
    chk({tag, "_bgn_count"},   bgn_cnt, 1);
    chk({tag, "_bgn_cycle"},   bgn_k,   2);
    chk({tag, "_res_data"},    bus.res_data, v.exp_data);
    chk({tag, "_res_err"},     bus.res_err,  v.exp_err);
    chk({tag, "_done_mulrst"}, mul_rst, 1);
    if (!v.no_fin) chk({tag, "_fin_to_valid"}, k_res, k_fin + 1);
    d0 = bus.res_data;
    e0 = bus.res_err;
    hold_ok = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_data !== d0 || bus.res_err !== e0 ||
          mul_rst !== 1'b1 || bus.op_ready !== 1'b0) hold_ok = 1'b0;
    end
    if (v.hold > 0) chk({tag, "_backpressure"}, hold_ok, 1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk({tag, "_idle_op_ready"},  bus.op_ready,  1);
    chk({tag, "_idle_res_valid"}, bus.res_valid, 0);
    chk({tag, "_idle_data_kept"}, bus.res_data,  d0);
  endtask

  vec_t vecs[6];
  vec_t v;
  bit   quiet;

  initial begin
    vecs[0] = '{16'd3,    16'd5,    32'h0000000F, 1'b0, 55, 0,  1'b0};
    vecs[1] = '{16'hFFFE, 16'd7,    32'hFFFFFFF2, 1'b0, 55, 0,  1'b0};
    vecs[2] = '{16'h8000, 16'h8000, 32'h40000000, 1'b0, 55, 10, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h8000, 32'hC0008000, 1'b0, 55, 0,  1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0, 55, 3,  1'b0};
    vecs[5] = '{16'h1234, 16'h0042, 32'h00000000, 1'b1, TIMEOUT + 3, 0, 1'b1};

    rst = 1'b1;
    bus.op_valid  = 1'b0;
    bus.op_q      = '0;
    bus.op_m      = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_op_ready", bus.op_ready, 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    fin_en = 1'b1;

    // Reset in WAIT cycle 20 (first WAIT cycle is 3 cycles after acceptance).
    bus.op_valid = 1'b1;
    bus.op_q     = 16'd9;
    bus.op_m     = 16'd11;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (21) @(negedge clk);
    chk("rst_mid_busy_before", busy, 1);
    chk("rst_mid_bgn_before",  mul_bgn, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("rst_mid");
    quiet = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("rst_mid_no_result", quiet, 1);

    v = '{16'd9, 16'd11, 32'd99, 1'b0, 55, 0, 1'b0};
    run_vec(v, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
